// File: rtl/rhythm_pkg.sv
// Shared types for the rhythm-game note path: lane count, the 4-bit row
// type, the spawner state encoding and a small popcount helper.
package rhythm_pkg;

  localparam int LANES = 4;

  typedef logic [LANES-1:0] row_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNTIN = 3'd1,
    ST_PLAY    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Number of lanes set in a row (0..4).
  function automatic logic [2:0] popcount(input row_t row);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      n = n + {2'b00, row[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/note_field.sv
// Scrolling note field: P_ROWS rows of 4 lanes. Row 0 (bits [3:0]) is the
// spawn row, row P_ROWS-1 is the hit line. A shift pushes every row one
// step toward the hit line, drops the old bottom row and loads new_row.
module note_field
  import rhythm_pkg::*;
#(
  parameter int P_ROWS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift,
  input  row_t                  new_row,
  output logic [4*P_ROWS-1:0]   field
);

  // Field register: reset/clear wins over shift; holds when not shifting.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      field <= '0;
    end else if (shift) begin
      field <= {field[4*(P_ROWS-1)-1:0], new_row};
    end
  end

endmodule

// File: rtl/note_spawner.sv
// Note spawner for a 4-lane rhythm game. On each beat in PLAY, the LFSR
// word decides whether a row spawns (low nibble < density) and which lanes
// it holds (high nibble, or a one-hot of bits [1:0] when the high nibble is
// zero). Rows scroll through note_field; the bottom row feeds the hit judge.
//
// Optional build macro: NOTE_SPAWNER_MAX2_EN -- when defined, a spawned row
// keeps only its two lowest-index lanes so no row asks for more than two
// simultaneous hits.
//
// Handshake: i_Beat and i_Start are single-cycle strobes with no back
// pressure. i_Start is honoured only in IDLE/DONE and then beats the beat
// in the same cycle; o_Spawn is a one-cycle pulse the cycle after the beat.
// o_State exposes the FSM state for observation.
module note_spawner
  import rhythm_pkg::*;
#(
  parameter int P_ROWS       = 8,
  parameter int P_COUNTIN    = 4,
  parameter int P_SONG_BEATS = 64
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [7:0]            i_Rand,
  input  logic                  i_Beat,
  input  logic                  i_Start,
  input  logic [3:0]            i_Density,
  output logic [4*P_ROWS-1:0]   o_Field,
  output logic [3:0]            o_HitRow,
  output logic                  o_Spawn,
  output logic [15:0]           o_NoteCnt,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [2:0]            o_State
);

  localparam logic [15:0] L_COUNTIN = 16'(P_COUNTIN);
  localparam logic [15:0] L_SONG    = 16'(P_SONG_BEATS);
  localparam logic [15:0] L_DRAIN   = 16'(P_ROWS);

  state_t      state;
  logic [15:0] beat_cnt;

  logic        start_ok;
  logic        shift_en;
  logic [15:0] cnt_next;
  logic [15:0] limit;
  logic        last_beat;
  logic        spawn_hit;
  row_t        raw_row;
  row_t        cand_row;
  row_t        new_row;
  logic [16:0] cnt_sum;

  // Beat/start qualification and end-of-phase detection.
  always_comb begin
    start_ok = i_Start && ((state == ST_IDLE) || (state == ST_DONE));
    shift_en = i_Beat && ((state == ST_COUNTIN) || (state == ST_PLAY) ||
                          (state == ST_DRAIN));
    cnt_next = beat_cnt + 16'd1;
    limit    = L_COUNTIN;
    case (state)
      ST_COUNTIN: limit = L_COUNTIN;
      ST_PLAY:    limit = L_SONG;
      ST_DRAIN:   limit = L_DRAIN;
      default:    limit = L_COUNTIN;
    endcase
    last_beat = shift_en && (cnt_next == limit);
  end

  // Spawn row selection; only PLAY inserts anything other than an empty row.
  always_comb begin
    spawn_hit = (i_Rand[3:0] < i_Density);
    if (i_Rand[7:4] == 4'd0) begin
      raw_row = row_t'(4'b0001 << i_Rand[1:0]);
    end else begin
      raw_row = i_Rand[7:4];
    end
`ifdef NOTE_SPAWNER_MAX2_EN
    begin
      row_t low1;
      row_t rest;
      row_t low2;
      low1     = raw_row & (~raw_row + 4'd1);
      rest     = raw_row & ~low1;
      low2     = rest & (~rest + 4'd1);
      cand_row = low1 | low2;
    end
`else
    cand_row = raw_row;
`endif
    new_row = ((state == ST_PLAY) && spawn_hit) ? cand_row : 4'd0;
    cnt_sum = {1'b0, o_NoteCnt} + {14'd0, popcount(new_row)};
  end

  // FSM, beat counter and registered status outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= ST_IDLE;
      beat_cnt  <= 16'd0;
      o_Spawn   <= 1'b0;
      o_NoteCnt <= 16'd0;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
    end else begin
      o_Spawn <= shift_en && (new_row != 4'd0);
      if (start_ok) begin
        state     <= ST_COUNTIN;
        beat_cnt  <= 16'd0;
        o_NoteCnt <= 16'd0;
        o_Busy    <= 1'b1;
        o_Done    <= 1'b0;
      end else if (shift_en) begin
        o_NoteCnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        if (last_beat) begin
          beat_cnt <= 16'd0;
          case (state)
            ST_COUNTIN: state <= ST_PLAY;
            ST_PLAY:    state <= ST_DRAIN;
            ST_DRAIN: begin
              state  <= ST_DONE;
              o_Busy <= 1'b0;
              o_Done <= 1'b1;
            end
            default:    state <= ST_IDLE;
          endcase
        end else begin
          beat_cnt <= cnt_next;
        end
      end
    end
  end

  note_field #(.P_ROWS(P_ROWS)) u_field (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .clr     (start_ok),
    .shift   (shift_en),
    .new_row (new_row),
    .field   (o_Field)
  );

  assign o_HitRow = o_Field[4*P_ROWS-1 -: 4];
  assign o_State  = state;

endmodule

// File: tb/tb_note_spawner.sv
// Directed bench for note_spawner with default parameters (8 rows,
// 4 count-in beats, 64 song beats). Expected values are hand-computed.
module tb_note_spawner;

  localparam int P_ROWS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rand_w;
  logic        beat;
  logic        start;
  logic [3:0]  density;
  logic [31:0] field;
  logic [3:0]  hit_row;
  logic        spawn;
  logic [15:0] note_cnt;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt;

  note_spawner #(.P_ROWS(P_ROWS), .P_COUNTIN(4), .P_SONG_BEATS(64)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Rand    (rand_w),
    .i_Beat    (beat),
    .i_Start   (start),
    .i_Density (density),
    .o_Field   (field),
    .o_HitRow  (hit_row),
    .o_Spawn   (spawn),
    .o_NoteCnt (note_cnt),
    .o_Busy    (busy),
    .o_Done    (done),
    .o_State   (state)
  );

  // clock
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic do_beat(input logic [7:0] r);
    @(negedge clk);
    beat   = 1'b1;
    rand_w = r;
    @(negedge clk);
    beat   = 1'b0;
  endtask

  task automatic do_start(input logic with_beat, input logic [7:0] r);
    @(negedge clk);
    start  = 1'b1;
    beat   = with_beat;
    rand_w = r;
    @(negedge clk);
    start  = 1'b0;
    beat   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; beat = 1'b0; start = 1'b0; rand_w = 8'h00; density = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (field !== 32'd0) begin errors++; $display("FAIL reset_field: got %h expected 0", field); end
    checks++; if (note_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", note_cnt); end
    checks++; if ({busy, done, spawn} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, spawn}); end
  endtask

  task automatic test_start_beat;
    density = 4'd15;
    do_start(1'b1, 8'hA3);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_beat_state: got %0d expected 1", state); end
    checks++; if (field !== 32'd0 || spawn !== 1'b0) begin errors++; $display("FAIL start_beat_noshift: field %h spawn %b expected 0 0", field, spawn); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    repeat (3) do_beat(8'hA3);
    checks++; if (state !== 3'd1 || field !== 32'd0) begin errors++; $display("FAIL countin_3: state %0d field %h expected 1 0", state, field); end
    do_beat(8'hA3);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL countin_4: got %0d expected 2", state); end
    exp_cnt = 16'd0;
  endtask

  task automatic test_spawn_a3;
    density = 4'd15;
    do_beat(8'hA3);
    exp_cnt = exp_cnt + 16'd2;
    checks++; if (field[3:0] !== 4'b1010) begin errors++; $display("FAIL a3_row0: got %b expected 1010", field[3:0]); end
    checks++; if (spawn !== 1'b1) begin errors++; $display("FAIL a3_spawn: got %b expected 1", spawn); end
    checks++; if (note_cnt !== exp_cnt) begin errors++; $display("FAIL a3_cnt: got %0d expected %0d", note_cnt, exp_cnt); end
    @(negedge clk);
    checks++; if (spawn !== 1'b0) begin errors++; $display("FAIL a3_pulse: got %b expected 0", spawn); end
    repeat (6) do_beat(8'h0F);
    checks++; if (hit_row !== 4'b0000 || field[27:24] !== 4'b1010) begin errors++; $display("FAIL a3_hit6: hit %b row6 %b expected 0000 1010", hit_row, field[27:24]); end
    do_beat(8'h0F);
    checks++; if (hit_row !== 4'b1010) begin errors++; $display("FAIL a3_hit7: got %b expected 1010", hit_row); end
  endtask

  task automatic test_pattern0;
    density = 4'd8;
    do_beat(8'h02);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (field[3:0] !== 4'b0100 || spawn !== 1'b1) begin errors++; $display("FAIL pat0_row: row %b spawn %b expected 0100 1", field[3:0], spawn); end
    checks++; if (note_cnt !== exp_cnt) begin errors++; $display("FAIL pat0_cnt: got %0d expected %0d", note_cnt, exp_cnt); end
    do_beat(8'h58);
    checks++; if (field[7:0] !== 8'h40 || spawn !== 1'b0) begin errors++; $display("FAIL nospawn_58: rows %h spawn %b expected 40 0", field[7:0], spawn); end
    checks++; if (note_cnt !== exp_cnt) begin errors++; $display("FAIL nospawn_cnt: got %0d expected %0d", note_cnt, exp_cnt); end
  endtask

  task automatic test_max2;
    logic [3:0] exp_f0;
    logic [3:0] exp_e0;
`ifdef NOTE_SPAWNER_MAX2_EN
    exp_f0 = 4'b0011; exp_e0 = 4'b0110;
`else
    exp_f0 = 4'b1111; exp_e0 = 4'b1110;
`endif
    density = 4'd15;
    do_beat(8'hF0);
    exp_cnt = exp_cnt + ((exp_f0 == 4'b1111) ? 16'd4 : 16'd2);
    checks++; if (field[3:0] !== exp_f0) begin errors++; $display("FAIL max2_f0_row: got %b expected %b", field[3:0], exp_f0); end
    checks++; if (note_cnt !== exp_cnt) begin errors++; $display("FAIL max2_f0_cnt: got %0d expected %0d", note_cnt, exp_cnt); end
    do_beat(8'hE0);
    exp_cnt = exp_cnt + ((exp_e0 == 4'b1110) ? 16'd3 : 16'd2);
    checks++; if (field[3:0] !== exp_e0) begin errors++; $display("FAIL max2_e0_row: got %b expected %b", field[3:0], exp_e0); end
    checks++; if (note_cnt !== exp_cnt) begin errors++; $display("FAIL max2_e0_cnt: got %0d expected %0d", note_cnt, exp_cnt); end
  endtask

  // 12 PLAY beats used so far; start pulses must not disturb the count
  task automatic test_start_ignored;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (state !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL start_in_play: state %0d busy %b expected 2 1", state, busy); end
    checks++; if (note_cnt !== exp_cnt) begin errors++; $display("FAIL start_in_play_cnt: got %0d expected %0d", note_cnt, exp_cnt); end
    repeat (50) do_beat(8'h0F);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL play_62: got %0d expected 2", state); end
    do_start(1'b1, 8'h0F);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL play_63: got %0d expected 2", state); end
    do_beat(8'h0F);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL play_64: got %0d expected 3", state); end
    repeat (7) do_beat(8'hA3);
    checks++; if (state !== 3'd3 || done !== 1'b0) begin errors++; $display("FAIL drain_7: state %0d done %b expected 3 0", state, done); end
    do_beat(8'hA3);
    checks++; if (state !== 3'd4 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL drain_8: state %0d done %b busy %b expected 4 1 0", state, done, busy); end
    checks++; if (field !== 32'd0 || note_cnt !== exp_cnt) begin errors++; $display("FAIL drain_end: field %h cnt %0d expected 0 %0d", field, note_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid;
    do_start(1'b1, 8'hA3);
    checks++; if (state !== 3'd1 || note_cnt !== 16'd0 || done !== 1'b0) begin errors++; $display("FAIL restart: state %0d cnt %0d done %b expected 1 0 0", state, note_cnt, done); end
    repeat (4) do_beat(8'h00);
    density = 4'd15;
    do_beat(8'hA3);
    do_beat(8'h0F);
    checks++; if (field[7:0] !== 8'hA0 || note_cnt !== 16'd2) begin errors++; $display("FAIL pre_reset: rows %h cnt %0d expected a0 2", field[7:0], note_cnt); end
    @(negedge clk); rst = 1'b1; start = 1'b1; beat = 1'b1; rand_w = 8'hF0;
    @(negedge clk); rst = 1'b0; start = 1'b0; beat = 1'b0;
    checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_state: state %0d busy %b expected 0 0", state, busy); end
    checks++; if (field !== 32'd0 || note_cnt !== 16'd0 || spawn !== 1'b0) begin errors++; $display("FAIL mid_reset_clear: field %h cnt %0d spawn %b expected 0 0 0", field, note_cnt, spawn); end
  endtask

  task automatic test_density0;
    int spawns;
    spawns  = 0;
    density = 4'd0;
    do_start(1'b0, 8'h00);
    for (int i = 1; i <= 76; i++) begin
      do_beat(8'(i * 37));
      if (spawn === 1'b1) spawns++;
      if (i == 4) begin
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL d0_play: got %0d expected 2", state); end
      end
      if (i == 68) begin
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL d0_drain: got %0d expected 3", state); end
      end
      if (i == 75) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL d0_done75: got %b expected 0", done); end
      end
    end
    checks++; if (done !== 1'b1 || state !== 3'd4) begin errors++; $display("FAIL d0_done76: done %b state %0d expected 1 4", done, state); end
    checks++; if (spawns !== 0 || note_cnt !== 16'd0) begin errors++; $display("FAIL d0_nospawn: spawns %0d cnt %0d expected 0 0", spawns, note_cnt); end
  endtask

  initial begin
    test_reset;
    test_start_beat;
    test_spawn_a3;
    test_pattern0;
    test_max2;
    test_start_ignored;
    test_reset_mid;
    test_density0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
